// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan capture path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [3:0] SEL_D0    = 4'b1110;
  localparam logic [3:0] SEL_D1    = 4'b1101;
  localparam logic [3:0] SEL_D2    = 4'b1011;
  localparam logic [3:0] SEL_D3    = 4'b0111;
  localparam logic [3:0] SEL_BLANK = 4'b1111;

  localparam logic [3:0] DIG_BAD = 4'hF;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_COLL = 1'b1
  } state_e;

  function automatic logic [13:0] bcd_to_bin(
    input logic [15:0] d
  );
    logic [13:0] acc;
    if (d[15:12] == DIG_BAD || d[11:8] == DIG_BAD ||
        d[7:4] == DIG_BAD || d[3:0] == DIG_BAD) begin
      acc = 14'h3FFF;
    end else begin
      acc = {10'd0, d[15:12]} * 14'd1000
          + {10'd0, d[11:8]} * 14'd100
          + {10'd0, d[7:4]} * 14'd10
          + {10'd0, d[3:0]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Unknown patterns map to DIG_BAD.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd
);

  always_comb begin
    bcd = DIG_BAD;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bcd = DIG_BAD;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the 4-digit multiplexed 7-segment scan.
// Define SEG_CAPTURE_BIN_EN to add the binary value_bin output.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FRAME_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  select,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        changed,
  output logic        frame_err,
  output logic        stale
`ifdef SEG_CAPTURE_BIN_EN
  ,
  output logic [13:0] value_bin
`endif
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] S_PRE = SW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] I_END = IW'(FRAME_TIMEOUT - 1);

  logic [3:0]    sel_q, prv_sel_q;
  logic [6:0]    seg_q, prv_seg_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [IW-1:0] idle_q, idle_d;
  state_e        state_q, state_d;
  logic [1:0]    exp_q, exp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   digits_q, digits_d;
  logic          pub_q, pub_d;
  logic          fv_q, fv_d;
  logic          chg_q, chg_d;
  logic          err_q, err_d;
  logic          stale_q, stale_d;
  logic [13:0]   bin_q, bin_d;

  logic          sel_ok;
  logic [1:0]    idx;
  logic          same;
  logic          acc;
  logic          tmo;
  logic [3:0]    dig;

  seg_pattern_decode u_dec (
    .seg (seg_q),
    .bcd (dig)
  );

  // Blanking and illegal codes both leave sel_ok low.
  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    case (sel_q)
      SEL_D0:  idx = 2'd0;
      SEL_D1:  idx = 2'd1;
      SEL_D2:  idx = 2'd2;
      SEL_D3:  idx = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    same   = (sel_q == prv_sel_q) && (seg_q == prv_seg_q);
    stab_d = '0;
    if (sel_ok) begin
      if (!same)               stab_d = SW'(1);
      else if (stab_q == S_MAX) stab_d = S_MAX;
      else                     stab_d = stab_q + SW'(1);
    end
    acc    = sel_ok && same && (stab_q == S_PRE);
    tmo    = !acc && (idle_q == I_END);
    idle_d = (acc || tmo) ? '0 : idle_q + IW'(1);
  end

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    shadow_d = shadow_q;
    digits_d = digits_q;
    pub_d    = 1'b0;
    fv_d     = 1'b0;
    chg_d    = 1'b0;
    err_d    = 1'b0;
    stale_d  = stale_q;
    bin_d    = bin_q;
    if (pub_q) begin
      digits_d = shadow_q;
      fv_d     = 1'b1;
      chg_d    = (shadow_q != digits_q);
      stale_d  = 1'b0;
      bin_d    = bcd_to_bin(shadow_q);
    end
    if (acc) begin
      case (state_q)
        ST_SYNC: begin
          if (idx == 2'd0) begin
            shadow_d[3:0] = dig;
            exp_d         = 2'd1;
            state_d       = ST_COLL;
          end
        end
        default: begin
          if (idx == exp_q) begin
            shadow_d[{idx, 2'b00} +: 4] = dig;
            exp_d = exp_q + 2'd1;
            pub_d = (exp_q == 2'd3);
          end else begin
            err_d = 1'b1;
            if (idx == 2'd0) begin
              shadow_d[3:0] = dig;
              exp_d         = 2'd1;
            end else begin
              exp_d   = 2'd0;
              state_d = ST_SYNC;
            end
          end
        end
      endcase
    end else if (tmo) begin
      stale_d  = 1'b1;
      state_d  = ST_SYNC;
      exp_d    = 2'd0;
      shadow_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= SEL_BLANK;
      seg_q     <= 7'h7F;
      prv_sel_q <= SEL_BLANK;
      prv_seg_q <= 7'h7F;
      stab_q    <= '0;
      idle_q    <= '0;
      state_q   <= ST_SYNC;
      exp_q     <= 2'd0;
      shadow_q  <= '0;
      digits_q  <= '0;
      pub_q     <= 1'b0;
      fv_q      <= 1'b0;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
      stale_q   <= 1'b1;
      bin_q     <= '0;
    end else begin
      sel_q     <= select;
      seg_q     <= seg;
      prv_sel_q <= sel_q;
      prv_seg_q <= seg_q;
      stab_q    <= stab_d;
      idle_q    <= idle_d;
      state_q   <= state_d;
      exp_q     <= exp_d;
      shadow_q  <= shadow_d;
      digits_q  <= digits_d;
      pub_q     <= pub_d;
      fv_q      <= fv_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      bin_q     <= bin_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = fv_q;
  assign changed     = chg_q;
  assign frame_err   = err_q;
  assign stale       = stale_q;

`ifdef SEG_CAPTURE_BIN_EN
  assign value_bin = bin_q;
`else
  logic unused_bin;
  assign unused_bin = ^bin_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a frame scoreboard.
// Honours SEG_CAPTURE_BIN_EN for the value_bin output.
module tb_seg_scan_capture;

  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;
  localparam logic [3:0] BL = 4'b1111;
  localparam int HOLD = 8;

  typedef struct {
    logic [15:0] d;
    logic        ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  select;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic        frame_valid;
  logic        changed;
  logic        frame_err;
  logic        stale;
`ifdef SEG_CAPTURE_BIN_EN
  logic [13:0] value_bin;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int err_ref;
  logic [15:0] model_last = 16'h0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seg_scan_capture #(
    .STABLE_CYCLES (4),
    .FRAME_TIMEOUT (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .select      (select),
    .seg         (seg),
    .digits      (digits),
    .frame_valid (frame_valid),
    .changed     (changed),
    .frame_err   (frame_err),
    .stale       (stale)
`ifdef SEG_CAPTURE_BIN_EN
    ,
    .value_bin   (value_bin)
`endif
  );

  function automatic logic [13:0] ref_bin(input logic [15:0] d);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      if (d[i*4 +: 4] > 4'd9) return 14'h3FFF;
      v = v * 10 + int'(d[i*4 +: 4]);
    end
    return 14'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && frame_err) err_cnt++;
    if (!rst && frame_valid) begin
      exp_t e;
      fv_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_frame observed=%0h expected=none", digits);
      end else begin
        e = sb.pop_front();
        chk("frame_digits", 32'(digits), 32'(e.d));
        chk("frame_changed", 32'(changed), 32'(e.ch));
`ifdef SEG_CAPTURE_BIN_EN
        chk("frame_bin", 32'(value_bin), 32'(ref_bin(e.d)));
`endif
      end
    end
  end

  task automatic put(input logic [3:0] s, input logic [6:0] p,
                     input int n);
    select = s;
    seg    = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3,
                       input logic [15:0] d);
    exp_t e;
    e.d  = d;
    e.ch = (d != model_last);
    model_last = d;
    sb.push_back(e);
    put(D0, p0, HOLD);
    put(D1, p1, HOLD);
    put(D2, p2, HOLD);
    put(D3, p3, HOLD);
  endtask

  initial begin
    rst    = 1'b1;
    select = BL;
    seg    = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
`ifdef SEG_CAPTURE_BIN_EN
    chk("rst_bin", 32'(value_bin), 32'h0);
`endif
    rst = 1'b0;
    put(BL, 7'h7F, 2);

    // 1: first frame
    frame(7'h79, 7'h24, 7'h30, 7'h19, 16'h4321);
    chk("t1_stale", 32'(stale), 32'h0);
    chk("t1_fvcnt", 32'(fv_cnt), 32'd1);

    // 2: repeated frame
    frame(7'h79, 7'h24, 7'h30, 7'h19, 16'h4321);
    chk("t2_fvcnt", 32'(fv_cnt), 32'd2);

    // 3: skipped D2
    err_ref = err_cnt;
    put(D0, 7'h79, HOLD);
    put(D1, 7'h24, HOLD);
    put(D3, 7'h19, HOLD);
    chk("t3_err", 32'(err_cnt), 32'(err_ref + 1));
    chk("t3_hold", 32'(digits), 32'h4321);
    frame(7'h40, 7'h40, 7'h40, 7'h79, 16'h1000);

    // 4: D1 glitching, then undecodable D2
    err_ref = err_cnt;
    sb.push_back('{d: 16'h4F21, ch: 1'b1});
    model_last = 16'h4F21;
    put(D0, 7'h79, HOLD);
    for (int i = 0; i < 6; i++) put(D1, i[0] ? 7'h30 : 7'h24, 2);
    chk("t4_noacc_err", 32'(err_cnt), 32'(err_ref));
    chk("t4_noacc_fv", 32'(fv_cnt), 32'd3);
    put(D1, 7'h24, HOLD);
    put(D2, 7'h7F, HOLD);
    put(D3, 7'h19, HOLD);
    chk("t4_err", 32'(err_cnt), 32'(err_ref));
    chk("t4_fvcnt", 32'(fv_cnt), 32'd4);

    // 5: timeout during a partial frame
    put(D0, 7'h12, HOLD);
    put(D1, 7'h02, HOLD);
    put(BL, 7'h7F, 100);
    chk("t5_not_stale", 32'(stale), 32'h0);
    put(BL, 7'h7F, 120);
    chk("t5_stale", 32'(stale), 32'h1);
    chk("t5_hold", 32'(digits), 32'h4F21);
    err_ref = err_cnt;
    put(D2, 7'h78, HOLD);
    put(D3, 7'h00, HOLD);
    put(BL, 7'h7F, 4);
    chk("t5_sync_err", 32'(err_cnt), 32'(err_ref));
    chk("t5_sync_fv", 32'(fv_cnt), 32'd4);
    frame(7'h12, 7'h02, 7'h78, 7'h00, 16'h8765);
    chk("t5_clear", 32'(stale), 32'h0);

    // 6: reset mid-frame
    put(D0, 7'h10, HOLD);
    put(D1, 7'h00, HOLD);
    rst = 1'b1;
    put(BL, 7'h7F, 2);
    rst = 1'b0;
    model_last = 16'h0;
    chk("t6_digits", 32'(digits), 32'h0);
    chk("t6_stale", 32'(stale), 32'h1);
    chk("t6_fv", 32'(frame_valid), 32'h0);
    err_ref = err_cnt;
    put(D2, 7'h02, HOLD);
    put(D3, 7'h12, HOLD);
    chk("t6_ign_err", 32'(err_cnt), 32'(err_ref));
    chk("t6_ign_fv", 32'(fv_cnt), 32'd5);
    frame(7'h10, 7'h00, 7'h02, 7'h12, 16'h5689);
    put(BL, 7'h7F, 4);

    chk("end_fvcnt", 32'(fv_cnt), 32'd6);
    chk("end_errcnt", 32'(err_cnt), 32'd1);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_stale", 32'(stale), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
